// File: rtl/ame_result_writer.sv
// Write-back stage for the affine ME solver: captures X0..X5 on start and writes them
// over an AXI4 write channel. Define AME_WR_BURST_EN for one INCR burst per start.
module ame_result_writer #(
    parameter int DATA_BITS   = 64,
    parameter int ADDR_BITS   = 32,
    parameter int NUM_RESULTS = 6
) (
    input  logic                             s_axi_aclk,
    input  logic                             s_axi_aresetn,
    input  logic [ADDR_BITS-1:0]             base_addr_i,
    input  logic                             start_i,
    input  logic                             affine_param6_i,
    input  logic [NUM_RESULTS*DATA_BITS-1:0] data_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             err_o,
    output logic [ADDR_BITS-1:0]             m_axi_awaddr,
    output logic [7:0]                       m_axi_awlen,
    output logic [2:0]                       m_axi_awsize,
    output logic [1:0]                       m_axi_awburst,
    output logic                             m_axi_awvalid,
    input  logic                             m_axi_awready,
    output logic [DATA_BITS-1:0]             m_axi_wdata,
    output logic [DATA_BITS/8-1:0]           m_axi_wstrb,
    output logic                             m_axi_wlast,
    output logic                             m_axi_wvalid,
    input  logic                             m_axi_wready,
    input  logic [1:0]                       m_axi_bresp,
    input  logic                             m_axi_bvalid,
    output logic                             m_axi_bready
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_RESULTS - 1);

    typedef enum logic [1:0] {IDLE, XFER, RESP, DONE} state_t;

    state_t                           state, state_n;
    logic [NUM_RESULTS*DATA_BITS-1:0] data_q, data_n;
    logic [ADDR_BITS-1:0]             addr_q, addr_n;
    logic [7:0]                       len_q, len_n;
    logic [2:0]                       idx_q, idx_n;
    logic                             awvalid_q, awvalid_n;
    logic                             wvalid_q, wvalid_n;
    logic                             aw_done_q, aw_done_n;
    logic                             w_done_q, w_done_n;
    logic                             err_q, err_n;
    logic                             aw_fire, w_fire, w_last_fire;

    // A transfer happens on any edge where valid && ready; a raised valid is held, with
    // address/data unchanged, until its ready arrives, then drops without waiting on the peer.
    always_comb begin
        state_n     = state;
        data_n      = data_q;
        addr_n      = addr_q;
        len_n       = len_q;
        idx_n       = idx_q;
        awvalid_n   = awvalid_q;
        wvalid_n    = wvalid_q;
        aw_done_n   = aw_done_q;
        w_done_n    = w_done_q;
        err_n       = err_q;
        aw_fire     = awvalid_q && m_axi_awready;
        w_fire      = wvalid_q && m_axi_wready;
        w_last_fire = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_n   = XFER;
                    data_n    = data_i;
                    addr_n    = affine_param6_i ? base_addr_i : base_addr_i + ADDR_BITS'(16);
                    idx_n     = affine_param6_i ? 3'd0 : 3'd2;
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                    err_n     = 1'b0;
`ifdef AME_WR_BURST_EN
                    len_n     = affine_param6_i ? 8'(NUM_RESULTS - 1) : 8'(NUM_RESULTS - 3);
`else
                    len_n     = 8'd0;
`endif
                end
            end
            XFER: begin
                awvalid_n = awvalid_q ? !m_axi_awready : !aw_done_q;
                if (aw_fire) aw_done_n = 1'b1;
`ifdef AME_WR_BURST_EN
                w_last_fire = w_fire && (idx_q == LAST_IDX);
                if (w_fire && !w_last_fire) idx_n = idx_q + 3'd1;
                wvalid_n = wvalid_q ? !w_last_fire : !w_done_q;
`else
                w_last_fire = w_fire;
                wvalid_n = wvalid_q ? !m_axi_wready : !w_done_q;
`endif
                if (w_last_fire) w_done_n = 1'b1;
                if ((aw_done_q || aw_fire) && (w_done_q || w_last_fire)) state_n = RESP;
            end
            RESP: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) err_n = 1'b1;
`ifdef AME_WR_BURST_EN
                    state_n = DONE;
`else
                    // An error response still lets the remaining slots go out.
                    if (idx_q == LAST_IDX) begin
                        state_n = DONE;
                    end else begin
                        idx_n     = idx_q + 3'd1;
                        addr_n    = addr_q + ADDR_BITS'(8);
                        aw_done_n = 1'b0;
                        w_done_n  = 1'b0;
                        state_n   = XFER;
                    end
`endif
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state     <= IDLE;
            data_q    <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            data_q    <= data_n;
            addr_q    <= addr_n;
            len_q     <= len_n;
            idx_q     <= idx_n;
            awvalid_q <= awvalid_n;
            wvalid_q  <= wvalid_n;
            aw_done_q <= aw_done_n;
            w_done_q  <= w_done_n;
            err_q     <= err_n;
        end
    end

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = 3'h3;
    assign m_axi_awburst = 2'h1;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = data_q[int'(idx_q)*DATA_BITS +: DATA_BITS];
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = wvalid_q;
`ifdef AME_WR_BURST_EN
    assign m_axi_wlast   = wvalid_q && (idx_q == LAST_IDX);
`else
    assign m_axi_wlast   = wvalid_q;
`endif
    assign m_axi_bready  = (state == RESP);
    assign busy_o        = (state == XFER) || (state == RESP);
    assign done_o        = (state == DONE);
    assign err_o         = err_q;

endmodule

// File: tb/tb_ame_result_writer.sv
// Directed bench for ame_result_writer: AXI slave model with programmable ready delays
// and error injection, scoreboard of AW/W/B traffic against hand-built expectations.
module tb_ame_result_writer;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam int NR = 6;

    logic              clk = 1'b0;
    logic              aresetn = 1'b0;
    logic [AW-1:0]     base_addr_i = '0;
    logic              start_i = 1'b0;
    logic              affine_param6_i = 1'b0;
    logic [NR*DW-1:0]  data_i = '0;
    logic              busy_o, done_o, err_o;
    logic [AW-1:0]     m_axi_awaddr;
    logic [7:0]        m_axi_awlen;
    logic [2:0]        m_axi_awsize;
    logic [1:0]        m_axi_awburst;
    logic              m_axi_awvalid;
    logic              m_axi_awready = 1'b0;
    logic [DW-1:0]     m_axi_wdata;
    logic [DW/8-1:0]   m_axi_wstrb;
    logic              m_axi_wlast, m_axi_wvalid;
    logic              m_axi_wready = 1'b0;
    logic [1:0]        m_axi_bresp = 2'b00;
    logic              m_axi_bvalid = 1'b0;
    logic              m_axi_bready;

    always #5 clk = ~clk;

    ame_result_writer #(.DATA_BITS(DW), .ADDR_BITS(AW), .NUM_RESULTS(NR)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(aresetn), .base_addr_i(base_addr_i),
        .start_i(start_i), .affine_param6_i(affine_param6_i), .data_i(data_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: AW entries are {awlen, awaddr}, W entries {wlast, wdata},
    // err entries are err_o as seen at each B handshake
    logic [63:0] exp_aw_q[$], got_aw_q[$];
    logic [64:0] exp_q[$], got_w_q[$];
    logic        exp_err_q[$], got_err_q[$];
    logic [63:0] x[NR];
    int aw_cnt = 0, wl_cnt = 0, b_done = 0, done_cnt = 0, stab_err = 0, err_b = -1;
    int aw_delay = 0, w_delay = 0, aw_wait = 0, w_wait = 0;
    logic aw_pend = 1'b0, w_pend = 1'b0;
    logic [AW-1:0] aw_hold = '0;
    logic [DW-1:0] w_hold = '0;

    always @(posedge clk) begin
        if (aresetn) begin
            if (aw_pend && (!m_axi_awvalid || m_axi_awaddr !== aw_hold)) stab_err++;
            if (w_pend && (!m_axi_wvalid || m_axi_wdata !== w_hold)) stab_err++;
            aw_pend = m_axi_awvalid && !m_axi_awready;
            w_pend  = m_axi_wvalid && !m_axi_wready;
            aw_hold = m_axi_awaddr;
            w_hold  = m_axi_wdata;
            if (m_axi_awvalid && m_axi_awready) begin
                got_aw_q.push_back({24'h0, m_axi_awlen, m_axi_awaddr});
                aw_cnt++;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                got_w_q.push_back({m_axi_wlast, m_axi_wdata});
                if (m_axi_wlast) wl_cnt++;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                got_err_q.push_back(err_o);
                b_done++;
            end
            if (done_o) done_cnt++;
        end else begin
            aw_pend = 1'b0;
            w_pend  = 1'b0;
        end
    end

    // slave model: ready after a programmable wait, B one cycle after both AW and last W
    always @(negedge clk) begin
        if (m_axi_awvalid) aw_wait++; else aw_wait = 0;
        if (m_axi_wvalid) w_wait++; else w_wait = 0;
        m_axi_awready = (aw_wait > aw_delay);
        m_axi_wready  = (w_wait > w_delay);
        m_axi_bvalid  = aresetn && (((aw_cnt < wl_cnt) ? aw_cnt : wl_cnt) > b_done);
        m_axi_bresp   = (b_done == err_b) ? 2'b10 : 2'b00;
    end

    task automatic clear_sb();
        exp_aw_q.delete(); got_aw_q.delete();
        exp_q.delete();    got_w_q.delete();
        exp_err_q.delete(); got_err_q.delete();
        aw_cnt = 0; wl_cnt = 0; b_done = 0; done_cnt = 0; stab_err = 0; err_b = -1;
    endtask

    task automatic set_data(input logic [63:0] seed, input logic [63:0] step);
        for (int i = 0; i < NR; i++) begin
            x[i] = seed + step * 64'(i);
            data_i[i*DW +: DW] = x[i];
        end
    endtask

    task automatic build_exp(input logic [AW-1:0] base, input logic p6);
        int first;
        first = p6 ? 0 : 2;
`ifdef AME_WR_BURST_EN
        exp_aw_q.push_back({24'h0, 8'(NR - 1 - first), base + 32'(8 * first)});
        for (int i = first; i < NR; i++) exp_q.push_back({(i == NR - 1), x[i]});
        exp_err_q.push_back(1'b0);
`else
        for (int i = first; i < NR; i++) begin
            exp_aw_q.push_back({24'h0, 8'h00, base + 32'(8 * i)});
            exp_q.push_back({1'b1, x[i]});
            exp_err_q.push_back((err_b >= 0) && ((i - first) > err_b));
        end
`endif
    endtask

    task automatic run_txn(input logic [AW-1:0] base, input logic p6, output int lat);
        @(negedge clk);
        base_addr_i = base;
        affine_param6_i = p6;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        lat = 1;
        check("busy_after_start", busy_o, 1'b1);
        check("err_clear_on_start", err_o, 1'b0);
        while (!done_o && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        check("done_seen", done_o, 1'b1);
        check("busy_low_at_done", busy_o, 1'b0);
    endtask

    task automatic check_sb(input string tag);
        repeat (3) @(negedge clk);
        check({tag, "_aw_count"}, got_aw_q.size(), exp_aw_q.size());
        foreach (exp_aw_q[i])
            if (i < got_aw_q.size()) check($sformatf("%s_aw%0d", tag, i), got_aw_q[i], exp_aw_q[i]);
        check({tag, "_w_count"}, got_w_q.size(), exp_q.size());
        foreach (exp_q[i])
            if (i < got_w_q.size()) check($sformatf("%s_w%0d", tag, i), got_w_q[i], exp_q[i]);
        check({tag, "_b_count"}, got_err_q.size(), exp_err_q.size());
        foreach (exp_err_q[i])
            if (i < got_err_q.size()) check($sformatf("%s_err_at_b%0d", tag, i), got_err_q[i], exp_err_q[i]);
        check({tag, "_stable"}, stab_err, 0);
        check({tag, "_done_pulses"}, done_cnt, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not complete");
    end

    initial begin
        int lat;
        int dc;

        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_awvalid", m_axi_awvalid, 1'b0);
        check("rst_wvalid", m_axi_wvalid, 1'b0);
        check("rst_bready", m_axi_bready, 1'b0);
        check("rst_awaddr", m_axi_awaddr, 32'h0);
        check("rst_awlen", m_axi_awlen, 8'h0);
        check("rst_wdata", m_axi_wdata, 64'h0);
        check("rst_wlast", m_axi_wlast, 1'b0);
        aresetn = 1'b1;
        @(negedge clk);
        check("const_awsize", m_axi_awsize, 3'h3);
        check("const_awburst", m_axi_awburst, 2'h1);
        check("const_wstrb", m_axi_wstrb, 8'hFF);

        // 6-param, ready tied high
        clear_sb();
        set_data(64'h11, 64'h11);
        build_exp(32'h8000_0000, 1'b1);
        run_txn(32'h8000_0000, 1'b1, lat);
`ifndef AME_WR_BURST_EN
        check("p6_latency", lat, 19);
`endif
        check("p6_err", err_o, 1'b0);
        check_sb("p6");

        // 4-param
        clear_sb();
        set_data(64'hA5A5_0000_0000_1000, 64'h0101);
        build_exp(32'h0000_1000, 1'b0);
        run_txn(32'h0000_1000, 1'b0, lat);
`ifndef AME_WR_BURST_EN
        check("p4_latency", lat, 13);
`endif
        check_sb("p4");

        // AW slow, W fast
        clear_sb();
        aw_delay = 3; w_delay = 1;
        set_data(64'h1234_5678_0000_0000, 64'h0F0F);
        build_exp(32'h4000_0100, 1'b1);
        run_txn(32'h4000_0100, 1'b1, lat);
        check_sb("bp_aw_slow");

        // W slow, AW fast
        clear_sb();
        aw_delay = 1; w_delay = 3;
        set_data(64'hFEDC_BA98_7654_3210, 64'h1);
        build_exp(32'h0000_2000, 1'b0);
        run_txn(32'h0000_2000, 1'b0, lat);
        check_sb("bp_w_slow");
        aw_delay = 0; w_delay = 0;

        // error response on one B
        clear_sb();
`ifdef AME_WR_BURST_EN
        err_b = 0;
`else
        err_b = 3;
`endif
        set_data(64'h11, 64'h11);
        build_exp(32'h8000_0000, 1'b1);
        run_txn(32'h8000_0000, 1'b1, lat);
        check("err_at_done", err_o, 1'b1);
        check_sb("bresp_err");

        // next start clears err; a second start mid-sequence is ignored
        clear_sb();
        set_data(64'h0C0C_0000, 64'h100);
        build_exp(32'h0000_3000, 1'b1);
        fork
            run_txn(32'h0000_3000, 1'b1, lat);
            begin
                repeat (6) @(negedge clk);
                data_i = {NR{64'hDEAD_BEEF_0BAD_F00D}};
                base_addr_i = 32'hFFFF_0000;
                affine_param6_i = 1'b0;
                start_i = 1'b1;
                @(negedge clk);
                start_i = 1'b0;
            end
        join
        check("err_cleared_next", err_o, 1'b0);
        check_sb("restart_ignored");

        // reset during XFER with both valids stuck high
        clear_sb();
        aw_delay = 1000; w_delay = 1000;
        set_data(64'h77, 64'h1);
        @(negedge clk);
        base_addr_i = 32'h0000_5000;
        affine_param6_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_awvalid", m_axi_awvalid, 1'b1);
        check("pre_rst_wvalid", m_axi_wvalid, 1'b1);
        dc = done_cnt;
        #2 aresetn = 1'b0;
        #1;
        check("mid_rst_awvalid", m_axi_awvalid, 1'b0);
        check("mid_rst_wvalid", m_axi_wvalid, 1'b0);
        check("mid_rst_bready", m_axi_bready, 1'b0);
        check("mid_rst_busy", busy_o, 1'b0);
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        aw_delay = 0; w_delay = 0;
        repeat (30) @(negedge clk);
        check("post_rst_no_done", done_cnt, dc);
        check("post_rst_busy", busy_o, 1'b0);
        check("post_rst_no_aw", got_aw_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ame_result_writer.md
Name: ame_result_writer

Overview:
- Downstream write-back stage for the affine ME equation solver.
- On a solver-done pulse, captures the fixed-point result vector X0..X5 and writes it to system memory over an AXI4 master write channel at a software-programmed base address.
- Supports 6-parameter mode (X0..X5) and 4-parameter mode (X2..X5 only).
- Runs in the s_axi_aclk domain, with the same clock as the solver and the register slave.

Parameters:
- DATA_BITS, 64, result word width; equals the AXI data width.
- ADDR_BITS, 32, AXI address width.
- NUM_RESULTS, 6, number of result slots.

Ports:
- s_axi_aclk  in  1  clock.
- s_axi_aresetn  in  1  reset.
- base_addr_i  in  ADDR_BITS  destination base address; sampled at start.
- start_i  in  1  single-cycle pulse from solver comp_done.
- affine_param6_i  in  1  1 = write X0..X5; 0 = write X2..X5; sampled at start.
- data_i  in  NUM_RESULTS*DATA_BITS  packed results; X0 in the LSBs.
- busy_o  out  1  high from start acceptance until done.
- done_o  out  1  one-cycle pulse when the final B response is received.
- err_o  out  1  sticky; set by any B response with bresp!=0.
- m_axi_awaddr  out  ADDR_BITS.
- m_axi_awlen  out  8.
- m_axi_awsize  out  3.
- m_axi_awburst  out  2.
- m_axi_awvalid  out  1.
- m_axi_awready  in  1.
- m_axi_wdata  out  DATA_BITS.
- m_axi_wstrb  out  DATA_BITS/8.
- m_axi_wlast  out  1.
- m_axi_wvalid  out  1.
- m_axi_wready  in  1.
- m_axi_bresp  in  2.
- m_axi_bvalid  in  1.
- m_axi_bready  out  1.

Behaviour:
- Clock and reset: clock s_axi_aclk; reset s_axi_aresetn, asynchronous, active-low.
- Reset values: all outputs 0, FSM in IDLE, capture registers 0.
- Constant outputs:
  - awsize = 3'h3 (8 bytes).
  - awburst = 2'h1 (INCR).
  - wstrb = all ones.
- Start acceptance:
  - start_i is accepted only in IDLE.
  - On acceptance, in the same edge: capture data_i, base_addr_i and affine_param6_i; clear err_o; set the slot index to 0 (6-param) or 2 (4-param); set busy_o.
  - start_i while busy is ignored. Captured data is not disturbed.
- Slot address: base + 8*idx. Fixed slot layout, so 4-param mode writes base+0x10..base+0x28.
- FSM, single-beat default (macro undefined):
  - IDLE -> XFER on accepted start.
  - XFER: awvalid and wvalid both asserted the cycle after entry.
    - awlen = 0, wlast = 1, wdata = slot[idx].
    - Each valid drops independently on its own ready handshake.
    - Go to RESP when both the AW and W handshakes have completed, in either order or in the same cycle.
  - RESP: bready = 1.
    - On bvalid: if bresp != 0, set err_o.
    - If idx == 5, go to DONE; otherwise increment idx and return to XFER.
  - DONE: done_o = 1 and busy_o drops in the same cycle; next state IDLE.
- AXI stability: awaddr, wdata and the valids stay stable while valid && !ready.
- Minimum latency with ready always high and bvalid one cycle after W: 3 cycles per slot plus 1 cycle DONE.
  - 6-param: done_o 19 cycles after the start edge.
  - 4-param: done_o 13 cycles after the start edge.
- An error response does not abort the sequence; the remaining slots are still written.
- Reset mid-transaction: all valids and bready drop asynchronously, the FSM returns to IDLE, and no done_o pulse is generated.
- bvalid outside RESP is ignored (bready = 0).

Optional Feature:
- Macro: AME_WR_BURST_EN.
- Defined: one INCR burst per start.
  - A single AW with awaddr = first slot address and awlen = 5 (6-param) or 3 (4-param).
  - W beats stream slot[idx] in order; wlast is asserted on the final beat only.
  - W beats may be issued before AW acceptance.
  - One B response is expected.
  - done_o follows that B response; err_o follows its bresp.
- Undefined: single-beat transactions as described in Behaviour.

Test Plan:
- 6-param, base 0x8000_0000, data X0..X5 = 0x11..0x66, ready tied high:
  - awaddr sequence 0x8000_0000, 0x8000_0008 .. 0x8000_0028.
  - wdata 0x11..0x66, each beat with wlast = 1.
  - done_o exactly 19 cycles after start; err_o = 0.
- 4-param, base 0x1000:
  - Exactly 4 writes at 0x1010, 0x1018, 0x1020, 0x1028 with data X2..X5.
  - done_o 13 cycles after start.
- Backpressure: awready delayed 3 cycles and wready delayed 1 cycle, and separately the reverse order:
  - awaddr, wdata and valids stay stable while waiting.
  - No beat is duplicated or dropped; the RESP transition happens only after both handshakes.
- bresp = 2'b10 on slot 3:
  - err_o rises at that B and stays high through done_o.
  - All 6 writes still occur.
  - The next accepted start clears err_o.
- start_i pulsed again mid-sequence with different data_i: ignored; original data is written. Then s_axi_aresetn asserted during XFER: all valids drop immediately, busy_o = 0, and no done_o pulse occurs.
- With AME_WR_BURST_EN, 6-param:
  - One AW with awlen = 5.
  - 6 W beats; wlast on beat 6 only.
  - One B response, then done_o.
